// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - writeback arbiter types, constants and sizing helper
package wb_pkg;

  typedef enum logic {ARB_PIPE, ARB_MCU} wb_arb_state_t;

  localparam int REG_NUM = 32;

  // Width needed to hold a saturating starvation count of 0..starve_max.
  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/defines.sv
// rtl/defines.sv - shared project-wide macros for the regfile writeback path
`ifndef REG_DATA_ZERO
`define REG_DATA_ZERO '0
`endif

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-mcu-write busy mask with set/clear ports
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [ADDR_W-1:0]  set_addr,
  input  logic               clr_en,
  input  logic [ADDR_W-1:0]  clr_addr,
  output logic [REG_NUM-1:0] busy
);

  // Clear first, then set, so a same-register issue and writeback leaves it busy; x0 is never marked.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (clr_en && clr_addr == ADDR_W'(i)) busy[i] <= 1'b0;
        if (set_en && set_addr == ADDR_W'(i) && i != 0) busy[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - pipe/mcu writeback port arbiter; WB_SCOREBOARD_EN enables the busy mask
`ifndef REG_DATA_ZERO
`define REG_DATA_ZERO '0
`endif

module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  output logic              pipe_ready,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mcu_valid,
  output logic              mcu_ready,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_data,
  input  logic              mcu_issue,
  input  logic [ADDR_W-1:0] mcu_issue_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       busy
);

  localparam int CNT_W = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  wb_arb_state_t    state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
  logic             pipe_acc, mcu_acc;

  assign pipe_acc = pipe_valid && pipe_ready;
  assign mcu_acc  = mcu_valid && mcu_ready;

  // Grant selection, starvation counting and priority flip decided from the current state.
  always_comb begin
    pipe_ready      = 1'b0;
    mcu_ready       = 1'b0;
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      ARB_PIPE: begin
        pipe_ready = pipe_valid;
        mcu_ready  = mcu_valid && !pipe_valid;
        if (mcu_valid && !mcu_ready && starve_cnt == CNT_LAST) state_next = ARB_MCU;
      end
      ARB_MCU: begin
        mcu_ready  = mcu_valid;
        pipe_ready = pipe_valid && !mcu_valid;
        if (!mcu_valid || mcu_ready) state_next = ARB_PIPE;
      end
      default: ;
    endcase
    if (!mcu_valid || mcu_ready)  starve_cnt_next = '0;
    else if (starve_cnt != CNT_MAX) starve_cnt_next = starve_cnt + CNT_W'(1);
  end

  // Register the winning request; x0 completes the handshake but never writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_PIPE;
      starve_cnt <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= `REG_DATA_ZERO;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      wr_en      <= (pipe_acc && pipe_addr != '0) || (mcu_acc && mcu_addr != '0);
      if (pipe_acc) begin
        wr_addr <= pipe_addr;
        wr_data <= pipe_data;
      end else if (mcu_acc) begin
        wr_addr <= mcu_addr;
        wr_data <= mcu_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (mcu_issue),
    .set_addr (mcu_issue_addr),
    .clr_en   (mcu_acc),
    .clr_addr (mcu_addr),
    .busy     (busy)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{mcu_issue, mcu_issue_addr};
  assign busy = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic        pipe_ready;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        mcu_valid = 1'b0;
  logic        mcu_ready;
  logic [4:0]  mcu_addr = '0;
  logic [31:0] mcu_data = '0;
  logic        mcu_issue = 1'b0;
  logic [4:0]  mcu_issue_addr = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  int  passed = 0;
  int  total  = 0;
  int  failed = 0;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB_ON = 1'b1;
`else
  localparam logic SB_ON = 1'b0;
`endif

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_addr(mcu_addr), .mcu_data(mcu_data),
    .mcu_issue(mcu_issue), .mcu_issue_addr(mcu_issue_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input logic exp_pr, input logic exp_mr, input string tag);
    wr_t e;
    #2;
    chk({tag, ".pipe_ready"}, 64'(pipe_ready), 64'(exp_pr));
    chk({tag, ".mcu_ready"},  64'(mcu_ready),  64'(exp_mr));
    if (rst)         e = '{en: 1'b0, addr: 5'd0, data: 32'd0};
    else if (exp_pr) e = '{en: (pipe_addr != 0), addr: pipe_addr, data: pipe_data};
    else if (exp_mr) e = '{en: (mcu_addr != 0), addr: mcu_addr, data: mcu_data};
    else             e = '{en: 1'b0, addr: 5'd0, data: 32'd0};
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(e.en));
    if (e.en) begin
      chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(e.addr));
      chk({tag, ".wr_data"}, 64'(wr_data), 64'(e.data));
    end
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, "rst0");
    step(1'b0, 1'b0, "rst1");
    chk("rst.wr_addr", 64'(wr_addr), 64'd0);
    chk("rst.wr_data", 64'(wr_data), 64'd0);
    chk("rst.busy",    64'(busy),    64'd0);
    rst = 1'b0;

    // Single pipe write, then idle with held addr/data
    pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, "pipe5");
    pipe_valid = 1'b0;
    step(1'b0, 1'b0, "idle");
    chk("idle.hold_addr", 64'(wr_addr), 64'd5);
    chk("idle.hold_data", 64'(wr_data), 64'hDEAD_BEEF);

    // Both requesting: pipe wins 0..3, mcu forced at 4, pipe again at 5
    mcu_valid = 1'b1; mcu_addr = 5'd12; mcu_data = 32'hC0DE_0012;
    pipe_valid = 1'b1; pipe_addr = 5'd3;
    for (int i = 0; i < 6; i++) begin
      pipe_data = 32'h1000_0000 + 32'(i);
      step(i != 4, i == 4, $sformatf("starve%0d", i));
    end
    pipe_valid = 1'b0; mcu_valid = 1'b0;
    step(1'b0, 1'b0, "drop");

    // mcu write to x0: handshake completes, no write
    mcu_valid = 1'b1; mcu_addr = 5'd0; mcu_data = 32'h1234;
    step(1'b0, 1'b1, "mcu_x0");
    mcu_valid = 1'b0;

    // Drive into ARB_MCU with pipe writes to x7, then reset mid-operation
    pipe_valid = 1'b1; pipe_addr = 5'd7; mcu_valid = 1'b1; mcu_addr = 5'd13;
    for (int i = 0; i < 4; i++) begin
      pipe_data = 32'h7700_0000 + 32'(i);
      step(1'b1, 1'b0, $sformatf("pre_rst%0d", i));
    end
    pipe_valid = 1'b0; mcu_valid = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, "mid_rst");
    chk("mid_rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    pipe_valid = 1'b1; mcu_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pipe_data = 32'h8800_0000 + 32'(i);
      step(i != 4, i == 4, $sformatf("post_rst%0d", i));
    end
    pipe_valid = 1'b0; mcu_valid = 1'b0;
    step(1'b0, 1'b0, "drop2");
    chk("pre_sb.busy", 64'(busy), 64'd0);

    // Busy scoreboard: issue, clear by accept, x0 never marked, set wins
    mcu_issue = 1'b1; mcu_issue_addr = 5'd9;
    step(1'b0, 1'b0, "issue9");
    mcu_issue = 1'b0;
    chk("issue9.busy", 64'(busy), SB_ON ? 64'h200 : 64'd0);
    mcu_valid = 1'b1; mcu_addr = 5'd9; mcu_data = 32'h9999_0001;
    step(1'b0, 1'b1, "acc9");
    mcu_valid = 1'b0;
    chk("acc9.busy", 64'(busy), 64'd0);
    mcu_issue = 1'b1; mcu_issue_addr = 5'd0;
    step(1'b0, 1'b0, "issue0");
    chk("issue0.busy", 64'(busy), 64'd0);
    mcu_issue_addr = 5'd9; mcu_valid = 1'b1; mcu_data = 32'h9999_0002;
    step(1'b0, 1'b1, "issue_acc9");
    mcu_issue = 1'b0; mcu_valid = 1'b0;
    chk("issue_acc9.busy", 64'(busy), SB_ON ? 64'h200 : 64'd0);
    mcu_valid = 1'b1; mcu_data = 32'h9999_0003;
    step(1'b0, 1'b1, "acc9b");
    mcu_valid = 1'b0;
    chk("acc9b.busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
